branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Dynamic branch predictor for the 5-stage pipeline: table of ENTRIES saturating counters indexed by PC bits.
//  IF stage looks up pred_pc_i and steers next PC on pred_taken_o.
//  ID stage, where branches resolve, writes the outcome back through the update port.
//  Also emits a registered mispredict pulse and saturating lookup/mispredict statistics.
// PARAMETERS
//  ENTRIES   16  table depth, power of 2 >= 2; IDX_W = log2(ENTRIES)
//  CTR_W     2   counter width; prediction = counter MSB
//  INIT_CTR  1   value loaded into every entry by reset/clear walk (weakly not-taken)
//  CNT_W     16  width of statistics counters
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      synchronous reset, active-high
//  start_i        in   1      core running; updates and stats counting only when 1
//  clear_i        in   1      pulse: restart table init walk from entry 0
//  pred_pc_i      in   32     IF-stage PC to predict
//  pred_valid_i   in   1      lookup is real (counted in lookup_cnt_o)
//  pred_taken_o   out  1      prediction for pred_pc_i, combinational
//  upd_valid_i    in   1      a branch resolved this cycle
//  upd_pc_i       in   32     PC of the resolved branch
//  upd_taken_i    in   1      actual outcome
//  upd_pred_i     in   1      prediction that was used for that branch
//  busy_o         out  1      init walk in progress
//  mispredict_o   out  1      registered 1-cycle pulse
//  lookup_cnt_o   out  CNT_W  saturating count of accepted lookups
//  mispred_cnt_o  out  CNT_W  saturating count of mispredicts
// BEHAVIOUR
//  Index: pred_idx = pred_pc_i[IDX_W+1:2]; upd_idx = upd_pc_i[IDX_W+1:2]. Bits [1:0] and upper bits are ignored (aliasing is allowed).
//  FSM states: INIT, RUN.
//   INIT:
//   - rst_i or clear_i -> INIT with walk ptr=0.
//   - Each cycle in INIT writes INIT_CTR to entry ptr, then ptr++.
//   - After writing entry ENTRIES-1 -> RUN.
//   - INIT lasts exactly ENTRIES cycles.
//   - clear_i in INIT restarts at ptr=0. clear_i in RUN enters INIT on the next edge.
//   - rst_i has priority over clear_i.
//  Reset values:
//   - busy_o=1, mispredict_o=0, lookup_cnt_o=0, mispred_cnt_o=0, state=INIT.
//   - clear_i does NOT zero the stats counters.
//  busy_o = (state==INIT). While busy_o:
//   - pred_taken_o=0.
//   - Updates are dropped: no table write, no mispredict, no count.
//   - Lookups are not counted.
//  Lookup: pred_taken_o = table[pred_idx][CTR_W-1] (zero-latency read).
//  Update:
//   - Accepted when upd_valid_i & start_i & RUN.
//   - Taken: saturating +1, holding at 2^CTR_W-1.
//   - Not taken: saturating -1, holding at 0.
//   - The new value is visible to lookups from the next cycle.
//   - Same-cycle lookup and update of the same index: the lookup returns the pre-update value (no bypass).
//  mispredict_o:
//   - Asserted the cycle after an accepted update with upd_taken_i != upd_pred_i.
//   - Otherwise 0; back-to-back mispredicts give back-to-back pulses.
//  Statistics counters:
//   - lookup_cnt_o += 1 per cycle with pred_valid_i & start_i & RUN.
//   - mispred_cnt_o += 1 per mispredict.
//   - Both saturate at 2^CNT_W-1 and never wrap.
//  start_i=0: table, counters and mispredict_o hold (mispredict_o=0). The init walk still advances.
// TESTING
//  T1 reset:
//   - Stimulus: rst_i for 1 cycle, ENTRIES=16.
//   - Required: busy_o=1 for exactly 16 cycles and pred_taken_o=0 throughout; then every PC predicts 0 (INIT_CTR=1), counters=0.
//  T2 training:
//   - Stimulus: taken updates at pc 0x40 on consecutive cycles.
//   - Required: counter 1->2->3; pred_taken_o(0x40)=1 from the cycle after the first update; extra taken updates hold at 3; one not-taken gives 2, still predicts 1; two more not-taken give 0.
//  T3 aliasing / same-cycle:
//   - Stimulus: update 0x80 taken; simultaneously look up 0x40.
//   - Required: lookup returns old value 0 that cycle and 1 the next (shared index 0); 0x44 (index 1) is unaffected.
//  T4 mispredict:
//   - Stimulus: 3 accepted updates with taken!=pred, then 1 with taken==pred.
//   - Required: mispredict_o=1 for 3 consecutive cycles then 0; mispred_cnt_o=3.
//  T5 saturation:
//   - Stimulus: CNT_W=4, 20 mispredicts and 20 valid lookups.
//   - Required: mispred_cnt_o=15 and lookup_cnt_o=15.
//  T6 clear mid-walk / mid-run:
//   - Clear at walk ptr=7 restarts the walk; busy_o stays 1 for 16 more cycles.
//   - Updates during busy_o leave the table and counters unchanged.
//   - Trained entries read INIT_CTR after the walk.

Source files
------------

// File: rtl/branch_predictor.sv
// Saturating-counter branch predictor with init walk,
// registered mispredict pulse and saturating statistics.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [31:0]      pred_pc_i,
  input  logic             pred_valid_i,
  output logic             pred_taken_o,
  input  logic             upd_valid_i,
  input  logic [31:0]      upd_pc_i,
  input  logic             upd_taken_i,
  input  logic             upd_pred_i,
  output logic             busy_o,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] lookup_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT_CTR);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CTR_W-1:0] tbl_q [ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [CTR_W-1:0] upd_cur;
  logic [CTR_W-1:0] upd_nxt;
  logic             upd_acc;
  logic             lkp_acc;
  logic             miss;
  logic             unused_pc_bits;

  assign pred_idx = pred_pc_i[IDX_W+1:2];
  assign upd_idx  = upd_pc_i[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0],
                            upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

  assign busy_o  = (state_q == INIT);
  assign upd_acc = upd_valid_i & start_i & ~busy_o & ~rst_i;
  assign lkp_acc = pred_valid_i & start_i & ~busy_o;
  assign miss    = upd_acc & (upd_taken_i != upd_pred_i);

  assign pred_taken_o = ~busy_o & tbl_q[pred_idx][CTR_W-1];

  assign upd_cur = tbl_q[upd_idx];

  always_comb begin
    upd_nxt = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != CTR_MAX) upd_nxt = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = RUN;
      end
      RUN: ;
      default: state_d = INIT;
    endcase
    // clear restarts the walk from entry 0 in either state
    if (clear_i) begin
      state_d = INIT;
      ptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (busy_o) tbl_q[ptr_q] <= INIT_V;
      else if (upd_acc) tbl_q[upd_idx] <= upd_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mispredict_o  <= 1'b0;
      lookup_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else begin
      mispredict_o <= miss;
      if (lkp_acc && lookup_cnt_o != '1)
        lookup_cnt_o <= lookup_cnt_o + 1'b1;
      if (miss && mispred_cnt_o != '1)
        mispred_cnt_o <= mispred_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed
// vectors plus random traffic against a reference model.
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int CNT_W   = 4;
  localparam int CTR_TOP = (1 << CTR_W) - 1;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             clear_i;
  logic [31:0]      pred_pc_i;
  logic             pred_valid_i;
  logic             pred_taken_o;
  logic             upd_valid_i;
  logic [31:0]      upd_pc_i;
  logic             upd_taken_i;
  logic             upd_pred_i;
  logic             busy_o;
  logic             mispredict_o;
  logic [CNT_W-1:0] lookup_cnt_o;
  logic [CNT_W-1:0] mispred_cnt_o;

  branch_predictor #(
    .ENTRIES(ENTRIES), .CTR_W(CTR_W),
    .INIT_CTR(1), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .start_i(start_i), .clear_i(clear_i),
    .pred_pc_i(pred_pc_i), .pred_valid_i(pred_valid_i),
    .pred_taken_o(pred_taken_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i),
    .upd_taken_i(upd_taken_i), .upd_pred_i(upd_pred_i),
    .busy_o(busy_o), .mispredict_o(mispredict_o),
    .lookup_cnt_o(lookup_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // reference model: counters as plain ints, walk as a countdown
  int mt [ENTRIES];
  int walk_left;
  int m_lc, m_mc;
  int m_mis;

  typedef struct {
    logic uv;
    logic ut;
    logic ep;
  } vec_t;
  vec_t tv [9];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int midx(logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  task automatic start_walk();
    walk_left = ENTRIES;
    foreach (mt[i]) mt[i] = 1;
  endtask

  task automatic model_reset();
    start_walk();
    m_lc  = 0;
    m_mc  = 0;
    m_mis = 0;
  endtask

  task automatic model_edge();
    bit acc, upd;
    int k;
    if (rst_i) begin
      model_reset();
      return;
    end
    acc   = (walk_left == 0) && start_i;
    upd   = acc && upd_valid_i;
    m_mis = (upd && upd_taken_i != upd_pred_i) ? 1 : 0;
    if (upd) begin
      k = midx(upd_pc_i);
      if (upd_taken_i) mt[k] = (mt[k] < CTR_TOP) ? mt[k] + 1 : CTR_TOP;
      else mt[k] = (mt[k] > 0) ? mt[k] - 1 : 0;
    end
    if (acc && pred_valid_i && m_lc < CNT_TOP) m_lc++;
    if (m_mis == 1 && m_mc < CNT_TOP) m_mc++;
    if (clear_i) start_walk();
    else if (walk_left > 0) walk_left--;
  endtask

  task automatic check_outputs();
    int ep;
    ep = (walk_left > 0) ? 0 : (mt[midx(pred_pc_i)] >= (CTR_TOP + 1) / 2);
    chk("m_busy", int'(busy_o), int'(walk_left > 0));
    chk("m_pred", int'(pred_taken_o), ep);
    chk("m_mis", int'(mispredict_o), m_mis);
    chk("m_lookup_cnt", int'(lookup_cnt_o), m_lc);
    chk("m_mispred_cnt", int'(mispred_cnt_o), m_mc);
  endtask

  task automatic step();
    #1 check_outputs();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic idle();
    clear_i = 0; upd_valid_i = 0; pred_valid_i = 0;
    upd_taken_i = 0; upd_pred_i = 0;
  endtask

  task automatic wait_walk(string name, int exp_len);
    int n = 0;
    while (busy_o && n < 40) begin
      #1 chk({name, "_pred_busy"}, int'(pred_taken_o), 0);
      step();
      n++;
    end
    chk({name, "_busy_len"}, n, exp_len);
  endtask

  int lc_snap;

  initial begin
    tv[0] = '{1, 1, 0}; tv[1] = '{1, 1, 1}; tv[2] = '{1, 1, 1};
    tv[3] = '{1, 1, 1}; tv[4] = '{1, 0, 1}; tv[5] = '{0, 0, 1};
    tv[6] = '{1, 0, 1}; tv[7] = '{1, 0, 0}; tv[8] = '{0, 0, 0};

    idle();
    rst_i = 1; start_i = 1; pred_pc_i = 0; upd_pc_i = 0;
    @(posedge clk_i);
    model_reset();
    @(negedge clk_i);
    rst_i = 0;

    // T1: reset walk, then every entry weakly not-taken
    #1 chk("t1_busy_rst", int'(busy_o), 1);
    chk("t1_cnt_rst", int'(lookup_cnt_o) + int'(mispred_cnt_o), 0);
    pred_pc_i = 32'h40;
    wait_walk("t1", 16);
    for (int i = 0; i < ENTRIES; i++) begin
      pred_pc_i = 32'(i * 4);
      #1 chk("t1_pred_init", int'(pred_taken_o), 0);
      step();
    end
    chk("t1_lookup_cnt", int'(lookup_cnt_o), 0);
    chk("t1_mispred_cnt", int'(mispred_cnt_o), 0);

    // T2: training at 0x40
    for (int i = 0; i < 9; i++) begin
      upd_valid_i = tv[i].uv; upd_pc_i = 32'h40;
      upd_taken_i = tv[i].ut; upd_pred_i = tv[i].ut;
      pred_pc_i = 32'h40; pred_valid_i = 1;
      #1 chk("t2_pred", int'(pred_taken_o), int'(tv[i].ep));
      step();
    end
    idle();

    // clear from RUN, then T3 same-cycle aliasing
    clear_i = 1;
    step();
    clear_i = 0;
    wait_walk("clr_run", 16);
    upd_valid_i = 1; upd_pc_i = 32'h80;
    upd_taken_i = 1; upd_pred_i = 1; pred_pc_i = 32'h40;
    #1 chk("t3_pred_same", int'(pred_taken_o), 0);
    step();
    idle();
    #1 chk("t3_pred_next", int'(pred_taken_o), 1);
    pred_pc_i = 32'h44;
    #1 chk("t3_pred_other", int'(pred_taken_o), 0);
    step();

    // T4: three mispredicts then a correct one
    for (int i = 0; i < 4; i++) begin
      upd_valid_i = 1; upd_pc_i = 32'h100;
      upd_taken_i = 1; upd_pred_i = (i == 3);
      step();
      #1 chk("t4_mis", int'(mispredict_o), int'(i < 3));
    end
    idle();
    step();
    chk("t4_mis_cnt", int'(mispred_cnt_o), 3);

    // T6: clear mid-run, clear again at walk ptr 7, updates while busy
    lc_snap = m_lc;
    clear_i = 1;
    step();
    clear_i = 0;
    upd_valid_i = 1; upd_pc_i = 32'h100;
    upd_taken_i = 0; upd_pred_i = 1; pred_valid_i = 1;
    for (int i = 0; i < 7; i++) step();
    clear_i = 1;
    step();
    clear_i = 0;
    wait_walk("t6", 16);
    idle();
    pred_pc_i = 32'h100;
    #1 chk("t6_pred_init", int'(pred_taken_o), 0);
    chk("t6_mis", int'(mispredict_o), 0);
    chk("t6_mis_cnt", int'(mispred_cnt_o), 3);
    chk("t6_lookup_cnt", int'(lookup_cnt_o), lc_snap);
    step();

    // T5: saturation of both statistics counters
    for (int i = 0; i < 20; i++) begin
      upd_valid_i = 1; upd_pc_i = 32'(i * 4);
      upd_taken_i = i[0]; upd_pred_i = ~i[0]; pred_valid_i = 1;
      step();
    end
    idle();
    step();
    chk("t5_mis_cnt", int'(mispred_cnt_o), 15);
    chk("t5_lookup_cnt", int'(lookup_cnt_o), 15);

    // random traffic against the model, with a reset to revisit counts
    rst_i = 1;
    step();
    rst_i = 0;
    for (int i = 0; i < 600; i++) begin
      rst_i        = ($urandom_range(0, 299) == 0);
      clear_i      = ($urandom_range(0, 63) == 0);
      start_i      = ($urandom_range(0, 7) != 0);
      pred_valid_i = $urandom_range(0, 1) == 1;
      upd_valid_i  = ($urandom_range(0, 3) != 0);
      upd_taken_i  = $urandom_range(0, 1) == 1;
      upd_pred_i   = $urandom_range(0, 1) == 1;
      pred_pc_i    = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 255));
      upd_pc_i     = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 255));
      step();
    end
    rst_i = 0;
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
